// File: rtl/cms_pix28_cmd_decoder.sv
// Command front end for the CMS pix28 test firmware: filters host words by firmware ID,
// decodes the op code, and owns the config registers, sticky status and read-back path.
module cms_pix28_cmd_decoder #(
    parameter logic [3:0] FIRMWARE_ID = 4'h1,
    parameter int         IP_SEL      = 1
) (
    input  logic        fw_axi_clk,
    input  logic        reset,
    input  logic [31:0] cmd_word,
    input  logic        cmd_valid,
    input  logic        test_busy,
    input  logic [3:0]  test_done,
    output logic [23:0] cfg_static_0_reg,
    output logic [23:0] cfg_static_1_reg,
    output logic [23:0] execute_cfg,
    output logic        execute_pulse,
    output logic        fw_rst_pulse,
    output logic [2:0]  cfg_array_wr,
    output logic [2:0]  cfg_array_rd,
    output logic [1:0]  data_array_rd,
    output logic [23:0] array_body,
    output logic [31:0] status,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    typedef enum logic [3:0] {
        OP_NOOP           = 4'h0,
        OP_W_RST_FW       = 4'h1,
        OP_W_CFG_STATIC_0 = 4'h2,
        OP_R_CFG_STATIC_0 = 4'h3,
        OP_W_CFG_STATIC_1 = 4'h4,
        OP_R_CFG_STATIC_1 = 4'h5,
        OP_W_CFG_ARRAY_0  = 4'h6,
        OP_R_CFG_ARRAY_0  = 4'h7,
        OP_W_CFG_ARRAY_1  = 4'h8,
        OP_R_CFG_ARRAY_1  = 4'h9,
        OP_W_CFG_ARRAY_2  = 4'hA,
        OP_R_CFG_ARRAY_2  = 4'hB,
        OP_R_DATA_ARRAY_0 = 4'hC,
        OP_R_DATA_ARRAY_1 = 4'hD,
        OP_W_STATUS_CLEAR = 4'hE,
        OP_W_EXECUTE      = 4'hF
    } op_t;

    logic [3:0]  device_id;
    op_t         op;
    logic [23:0] body;
    logic        accept;
    logic [3:0]  test_number;
    logic        exec_ok;
    logic [31:0] status_next;

    assign device_id   = cmd_word[31:28];
    assign op          = op_t'(cmd_word[27:24]);
    assign body        = cmd_word[23:0];
    assign accept      = cmd_valid && ((device_id & FIRMWARE_ID) != 4'h0);
    assign test_number = (IP_SEL == 2) ? cmd_word[15:12] : cmd_word[17:14];
    assign exec_ok     = $onehot(test_number) && !test_busy;

    // Clear first, then OR in completion bits and the command's own bit, so a
    // test_done pulse coinciding with a clear is never lost.
    // NOTE: status_next gets a full default before any conditional write so no latch is inferred.
    always_comb begin
        status_next = status;
        if (accept && (op == OP_W_RST_FW || op == OP_W_STATUS_CLEAR))
            status_next = '0;
        status_next[17:14] = status_next[17:14] | test_done;
        if (accept) begin
            case (op)
                OP_W_RST_FW:       status_next[0]  = 1'b1;
                OP_W_CFG_STATIC_0: status_next[1]  = 1'b1;
                OP_R_CFG_STATIC_0: status_next[2]  = 1'b1;
                OP_W_CFG_STATIC_1: status_next[3]  = 1'b1;
                OP_R_CFG_STATIC_1: status_next[4]  = 1'b1;
                OP_W_CFG_ARRAY_0:  status_next[5]  = 1'b1;
                OP_R_CFG_ARRAY_0:  status_next[6]  = 1'b1;
                OP_W_CFG_ARRAY_1:  status_next[7]  = 1'b1;
                OP_R_CFG_ARRAY_1:  status_next[8]  = 1'b1;
                OP_W_CFG_ARRAY_2:  status_next[9]  = 1'b1;
                OP_R_CFG_ARRAY_2:  status_next[10] = 1'b1;
                OP_R_DATA_ARRAY_0: status_next[11] = 1'b1;
                OP_R_DATA_ARRAY_1: status_next[12] = 1'b1;
                OP_W_EXECUTE: begin
                    if (exec_ok) status_next[13] = 1'b1;
                    else         status_next[31] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fw_axi_clk) begin
        if (reset) begin
            cfg_static_0_reg <= '0;
            cfg_static_1_reg <= '0;
            execute_cfg      <= '0;
            execute_pulse    <= 1'b0;
            fw_rst_pulse     <= 1'b0;
            cfg_array_wr     <= '0;
            cfg_array_rd     <= '0;
            data_array_rd    <= '0;
            array_body       <= '0;
            status           <= '0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
        end else begin
            execute_pulse <= 1'b0;
            fw_rst_pulse  <= 1'b0;
            cfg_array_wr  <= '0;
            cfg_array_rd  <= '0;
            data_array_rd <= '0;
            rd_valid      <= 1'b0;
            status        <= status_next;
            if (accept) begin
                case (op)
                    OP_W_RST_FW: begin
                        cfg_static_0_reg <= '0;
                        cfg_static_1_reg <= '0;
                        execute_cfg      <= '0;
                        fw_rst_pulse     <= 1'b1;
                    end
                    OP_W_CFG_STATIC_0: cfg_static_0_reg <= body;
                    OP_R_CFG_STATIC_0: begin
                        rd_data  <= {cmd_word[31:24], cfg_static_0_reg};
                        rd_valid <= 1'b1;
                    end
                    OP_W_CFG_STATIC_1: cfg_static_1_reg <= body;
                    OP_R_CFG_STATIC_1: begin
                        rd_data  <= {cmd_word[31:24], cfg_static_1_reg};
                        rd_valid <= 1'b1;
                    end
                    OP_W_CFG_ARRAY_0: begin cfg_array_wr[0] <= 1'b1; array_body <= body; end
                    OP_R_CFG_ARRAY_0: begin cfg_array_rd[0] <= 1'b1; array_body <= body; end
                    OP_W_CFG_ARRAY_1: begin cfg_array_wr[1] <= 1'b1; array_body <= body; end
                    OP_R_CFG_ARRAY_1: begin cfg_array_rd[1] <= 1'b1; array_body <= body; end
                    OP_W_CFG_ARRAY_2: begin cfg_array_wr[2] <= 1'b1; array_body <= body; end
                    OP_R_CFG_ARRAY_2: begin cfg_array_rd[2] <= 1'b1; array_body <= body; end
                    OP_R_DATA_ARRAY_0: data_array_rd[0] <= 1'b1;
                    OP_R_DATA_ARRAY_1: data_array_rd[1] <= 1'b1;
                    OP_W_EXECUTE: begin
                        if (exec_ok) begin
                            execute_cfg   <= body;
                            execute_pulse <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cms_pix28_cmd_decoder.sv
// Directed bench for cms_pix28_cmd_decoder; expected output snapshots are queued
// with each driven word and compared one cycle later.
module tb_cms_pix28_cmd_decoder;

    typedef struct packed {
        logic [23:0] cfg0;
        logic [23:0] cfg1;
        logic [23:0] exec_cfg;
        logic        exec_pulse;
        logic        fw_rst;
        logic [2:0]  arr_wr;
        logic [2:0]  arr_rd;
        logic [1:0]  data_rd;
        logic [23:0] arr_body;
        logic [31:0] status;
        logic [31:0] rd_data;
        logic        rd_valid;
    } snap_t;

    logic        fw_axi_clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_word;
    logic        cmd_valid;
    logic        test_busy;
    logic [3:0]  test_done;
    logic [23:0] cfg_static_0_reg, cfg_static_1_reg, execute_cfg, array_body;
    logic        execute_pulse, fw_rst_pulse, rd_valid;
    logic [2:0]  cfg_array_wr, cfg_array_rd;
    logic [1:0]  data_array_rd;
    logic [31:0] status, rd_data;

    int    vectors     = 0;
    int    miscompares = 0;
    snap_t e;
    snap_t exp_q[$];
    string tag_q[$];

    always #5 fw_axi_clk = ~fw_axi_clk;

    cms_pix28_cmd_decoder #(.FIRMWARE_ID(4'h1), .IP_SEL(1)) dut (
        .fw_axi_clk       (fw_axi_clk),
        .reset            (reset),
        .cmd_word         (cmd_word),
        .cmd_valid        (cmd_valid),
        .test_busy        (test_busy),
        .test_done        (test_done),
        .cfg_static_0_reg (cfg_static_0_reg),
        .cfg_static_1_reg (cfg_static_1_reg),
        .execute_cfg      (execute_cfg),
        .execute_pulse    (execute_pulse),
        .fw_rst_pulse     (fw_rst_pulse),
        .cfg_array_wr     (cfg_array_wr),
        .cfg_array_rd     (cfg_array_rd),
        .data_array_rd    (data_array_rd),
        .array_body       (array_body),
        .status           (status),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid)
    );

    task automatic check_out();
        snap_t obs;
        snap_t exp_s;
        string tag;
        obs = '{cfg_static_0_reg, cfg_static_1_reg, execute_cfg, execute_pulse, fw_rst_pulse,
                cfg_array_wr, cfg_array_rd, data_array_rd, array_body, status, rd_data, rd_valid};
        exp_s = exp_q.pop_front();
        tag   = tag_q.pop_front();
        vectors++;
        assert (obs === exp_s) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_s);
        end
    endtask

    // One clock of stimulus; the current expectation e describes the outputs after this edge.
    task automatic step(input logic [31:0] w, input logic v, input logic busy,
                        input logic [3:0] done, input string tag);
        cmd_word  = w;
        cmd_valid = v;
        test_busy = busy;
        test_done = done;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge fw_axi_clk);
        #1;
        cmd_valid = 1'b0;
        test_done = 4'h0;
        test_busy = 1'b0;
        check_out();
        e.exec_pulse = 1'b0;
        e.fw_rst     = 1'b0;
        e.arr_wr     = 3'b000;
        e.arr_rd     = 3'b000;
        e.data_rd    = 2'b00;
        e.rd_valid   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_word = '0; cmd_valid = 1'b0; test_busy = 1'b0; test_done = 4'h0;
        e = '0;
        step(32'h0, 1'b0, 1'b0, 4'h0, "reset_state");
        reset = 1'b0;

        step(32'h2200FFFF, 1'b1, 1'b0, 4'h0, "reject_id");

        e.cfg0 = 24'h00ABCD; e.status = 32'h2;
        step(32'h1200ABCD, 1'b1, 1'b0, 4'h0, "w_cfg0");
        e.rd_data = 32'h1300ABCD; e.rd_valid = 1'b1; e.status = 32'h6;
        step(32'h13000000, 1'b1, 1'b0, 4'h0, "r_cfg0");
        step(32'h0, 1'b0, 1'b0, 4'h0, "rd_hold");

        e.exec_cfg = 24'h004000; e.exec_pulse = 1'b1; e.status = 32'h00002006;
        step(32'h1F004000, 1'b1, 1'b0, 4'h0, "exec_ok");
        step(32'h0, 1'b0, 1'b0, 4'h0, "exec_pulse_end");

        e.status = 32'h80002006;
        step(32'h1F00C000, 1'b1, 1'b0, 4'h0, "exec_not_onehot");
        step(32'h1F008000, 1'b1, 1'b1, 4'h0, "exec_busy");
        step(32'h1F000000, 1'b1, 1'b0, 4'h0, "exec_zero");

        e.cfg1 = 24'h000123; e.status = 32'h8000200E;
        step(32'h14000123, 1'b1, 1'b0, 4'h0, "w_cfg1");
        e.rd_data = 32'h15000123; e.rd_valid = 1'b1; e.status = 32'h8000201E;
        step(32'h15000000, 1'b1, 1'b0, 4'h0, "r_cfg1_b2b");

        e.status = 32'h00008000;
        step(32'h1E000000, 1'b1, 1'b0, 4'b0010, "clear_with_done");
        e.status = 32'h0000C000;
        step(32'h0, 1'b0, 1'b0, 4'b0001, "done_alone");

        e.arr_wr = 3'b100; e.arr_body = 24'h000055; e.status = 32'h0000C200;
        step(32'h1A000055, 1'b1, 1'b0, 4'h0, "w_array2");
        step(32'h0, 1'b0, 1'b0, 4'h0, "array_strobe_end");
        e.arr_rd = 3'b001; e.arr_body = 24'h000077; e.status = 32'h0000C240;
        step(32'h17000077, 1'b1, 1'b0, 4'h0, "r_array0");
        e.data_rd = 2'b10; e.status = 32'h0000D240;
        step(32'h1D000000, 1'b1, 1'b0, 4'h0, "r_data1");
        step(32'h10000000, 1'b1, 1'b0, 4'h0, "noop");

        e.fw_rst = 1'b1; e.cfg0 = '0; e.cfg1 = '0; e.exec_cfg = '0; e.status = 32'h1;
        step(32'h11000000, 1'b1, 1'b0, 4'h0, "rst_fw");
        e.fw_rst = 1'b1; e.status = 32'h00020001;
        step(32'h11000000, 1'b1, 1'b0, 4'b1000, "rst_fw_with_done");

        e.cfg0 = 24'h00AAAA; e.status = 32'h00020003;
        step(32'h1200AAAA, 1'b1, 1'b0, 4'h0, "w_cfg0_again");
        reset = 1'b1;
        e = '0;
        step(32'h1F004000, 1'b1, 1'b0, 4'h0, "reset_wins");
        reset = 1'b0;
        step(32'h0, 1'b0, 1'b0, 4'h0, "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
